// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: valid/ready input, 2-entry registered
// output queue, illegal-format flagging and a saturating illegal-beat counter.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 8,
  parameter int AUTO_DECODE = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clear
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_CSR   = 3'b101,
    FMT_SHAMT = 3'b110,
    FMT_ILL   = 3'b111
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] t;
    t = $signed(v);
    return t;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  fmt_e       w_auto_fmt;
  fmt_e       w_fmt;
  logic       w_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];

  always_comb begin
    // NOTE: default assigned first so every path drives the signal; no latch is inferred
    w_auto_fmt = FMT_ILL;
    case (w_opcode)
      OP_LOAD, OP_JALR: w_auto_fmt = FMT_I;
      OP_IMM:           w_auto_fmt = (w_funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
      OP_STORE:         w_auto_fmt = FMT_S;
      OP_BRANCH:        w_auto_fmt = FMT_B;
      OP_JAL:           w_auto_fmt = FMT_J;
      OP_LUI, OP_AUIPC: w_auto_fmt = FMT_U;
      OP_SYSTEM:        w_auto_fmt = w_funct3[2] ? FMT_CSR : FMT_I;
      default:          w_auto_fmt = FMT_ILL;
    endcase
  end

  assign w_fmt     = (AUTO_DECODE != 0) ? w_auto_fmt : fmt_e'(in_immsrc);
  assign w_illegal = (w_fmt == FMT_ILL);

  // ------------------------------------------------------------- immediates
  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [XLEN-1:0] w_imm_csr, w_imm_shamt, w_imm;

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};

  assign w_imm_csr   = XLEN'(in_instr[19:15]);
  // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one
  assign w_imm_shamt = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I:     w_imm = sext32(w_imm_i);
      FMT_S:     w_imm = sext32(w_imm_s);
      FMT_B:     w_imm = sext32(w_imm_b);
      FMT_J:     w_imm = sext32(w_imm_j);
      FMT_U:     w_imm = sext32(w_imm_u);
      FMT_CSR:   w_imm = w_imm_csr;
      FMT_SHAMT: w_imm = w_imm_shamt;
      default:   w_imm = '0;
    endcase
  end

  // ------------------------------------------------------------ handshake
  logic             r_in_ready;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = (r_count != 2'd0) && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // ---------------------------------------------------------------- queue
  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic [1:0]       r_ill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the two entries are reset so the head fields read zero straight out of reset
      r_imm[0] <= '0;
      r_imm[1] <= '0;
      r_tag[0] <= '0;
      r_tag[1] <= '0;
      r_ill    <= 2'b00;
    end else if (w_push) begin
      r_imm[r_wr_ptr] <= w_imm;
      r_tag[r_wr_ptr] <= in_tag;
      r_ill[r_wr_ptr] <= w_illegal;
    end
  end

  // ------------------------------------------------------ illegal counter
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cnt_clear) begin
      r_cnt <= '0;
    end else if (w_push && w_illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_imm     = r_imm[r_rd_ptr];
  assign out_tag     = r_tag[r_rd_ptr];
  assign out_illegal = r_ill[r_rd_ptr];
  assign occupancy   = r_count;
  assign illegal_cnt = r_cnt;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender in the RISC-V datapath.
- Accepts a 32-bit instruction, a format select and a tag through a valid/ready handshake.
- Produces an XLEN-wide immediate through a registered 2-entry output queue, with illegal-format flagging and a saturating illegal counter.
- Sits between decode and execute in the pipelined core; also usable as a stall-tolerant stage.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 8, width of the pass-through tag (instruction ID or PC bits).
- AUTO_DECODE, 0, when 1 the format is derived from instr[6:0] and in_immsrc is ignored.
- CNT_W, 16, width of the saturating illegal-format counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_instr  in  32  instruction word.
- in_immsrc  in  3  format select; ignored when AUTO_DECODE=1.
- in_tag  in  TAG_W  tag carried alongside the result.
- out_valid  out  1  head of queue valid.
- out_ready  in  1  consumer accepts the head.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the head entry.
- out_illegal  out  1  head entry had an illegal format.
- occupancy  out  2  queue entries held, 0..2.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal beats.
- cnt_clear  in  1  synchronous clear of illegal_cnt.

Behaviour:
- Reset (async, active-high): queue emptied; out_valid=0, out_imm=0, out_tag=0, out_illegal=0, occupancy=0, illegal_cnt=0. in_ready=1 from the first edge after reset deasserts. Reset mid-transfer discards all held entries.
- Formats (immsrc code), sign bit instr[31] replicated to XLEN:
  - 000 I: instr[31:20] sign-extended.
  - 001 S: {instr[31:25], instr[11:7]} sign-extended.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - 100 U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 101 CSR uimm: instr[19:15] zero-extended.
  - 110 shamt: zero-extended; instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 111: illegal; imm=0, illegal=1.
- AUTO_DECODE opcode map:
  - 0000011, 0010011, 1100111 -> I; except 0010011 with funct3 001/101 -> shamt.
  - 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111/0010111 -> U.
  - 1110011 with funct3[2]=1 -> CSR uimm; 1110011 with funct3[2]=0 -> I.
  - Any other opcode -> illegal.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = (occupancy < 2); it is registered-state only and has no combinational path from out_ready.
  - out_valid = (occupancy != 0). Output fields are driven from queue head registers, with no combinational path from inputs.
- Latency: an accepted beat appears at the output on the next rising edge when the queue is empty or drains that cycle. Throughput is 1 beat/cycle with out_ready held high.
- Queue: 2-entry FIFO with 1-bit read and write pointers that wrap. Order is preserved.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Allowed at occupancy 1 and 2. At 2, in_ready=0, so no push occurs.
  - At occupancy 0 only a push can occur, because there is no head to pop.
- Stall: while out_valid && !out_ready, the head fields stay stable.
- illegal_cnt:
  - +1 per accepted illegal beat, saturating at 2^CNT_W-1.
  - cnt_clear has priority over increment; clear and an illegal accept in the same cycle give 0.
- Non-accepted inputs (in_valid=0 or in_ready=0) have no effect on state or counter.

Test Plan:
- XLEN=32, immsrc=000, instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0, occupancy=1.
- XLEN=64, AUTO_DECODE=1, instr=0x800000EF (jal, imm sign bit set) -> out_imm=0xFFFFFFFFFFF00000. instr=0x000153B7 (lui) -> out_imm=0x0000000000015000.
- Backpressure: out_ready=0, push tags 1,2,3 on consecutive cycles -> tags 1,2 accepted, in_ready=0 at occupancy 2, tag 3 held. Raise out_ready -> outputs 1,2,3 in order with no loss or duplication.
- Continuous stream of 10 beats with out_ready=1 -> one beat per cycle, occupancy stays 1, no bubble.
- immsrc=111 on 3 beats, then cnt_clear together with a 4th illegal beat -> out_illegal=1 and out_imm=0 on each, illegal_cnt = 3 then 0. CNT_W=2 with 5 illegal beats -> saturates at 3.
- Assert reset with occupancy=2 -> immediately occupancy=0, out_valid=0, illegal_cnt=0. After release, the first beat returns with 1-cycle latency.
